// File: rtl/instruction_dispatcher.sv
// -----------------------------------------------------------------------------
// instruction_dispatcher
//
// Buffers 32-bit instructions from a host in a FIFO and feeds them to the
// 4-stage core one at a time. Each issue is a single-cycle coreValid pulse.
// The instruction is then held stable until the core reports completion.
// A watchdog drops any instruction that the core never completes.
//
// Parameters
//   DEPTH        FIFO entries (power of 2, >= 2)
//   TIMEOUT      max BUSY cycles to wait for coreComplete (>= 8)
//   COUNT_WIDTH  width of the statistics counters
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-low reset
//   hostInstruction  instruction to enqueue
//   hostValid        host offers hostInstruction
//   hostReady        FIFO can accept (push = hostValid && hostReady)
//   coreInstruction  instruction to the core, held from ISSUE through BUSY
//   coreValid        one-cycle issue pulse to the core
//   coreComplete     completion strobe from the core (honoured only in BUSY)
//   queueCount       FIFO occupancy
//   busy             dispatcher state is not IDLE
//   timeoutFlag      sticky, set on any watchdog drop
//   issuedCount      instructions completed by the core
//   droppedCount     instructions dropped by the watchdog
//   idleCycles       cycles spent IDLE with an empty FIFO
//
// Build option
//   DISPATCH_PERF_EN  when defined, the idleCycles counter is built.
//                     When it is undefined, idleCycles is tied to zero.
// -----------------------------------------------------------------------------
module instruction_dispatcher #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              hostInstruction,
   input  logic                     hostValid,
   output logic                     hostReady,
   output logic [31:0]              coreInstruction,
   output logic                     coreValid,
   input  logic                     coreComplete,
   output logic [$clog2(DEPTH):0]   queueCount,
   output logic                     busy,
   output logic                     timeoutFlag,
   output logic [COUNT_WIDTH-1:0]   issuedCount,
   output logic [COUNT_WIDTH-1:0]   droppedCount,
   output logic [COUNT_WIDTH-1:0]   idleCycles
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      BUSY  = 2'b10
   } state_e;

   // ---------------------------------------------------------------- FIFO
   logic [31:0]            mem [DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;

   // ---------------------------------------------------------------- FSM
   state_e                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [31:0]            instr_q, instr_d;
   logic                   valid_q, valid_d;
   logic                   flag_q, flag_d;
   logic [COUNT_WIDTH-1:0] issued_q, issued_d;
   logic [COUNT_WIDTH-1:0] dropped_q, dropped_d;

   logic push;
   logic pop;

   assign hostReady = (count_q < DEPTH_C);
   assign push      = hostValid && hostReady;
   // Dequeue happens only when the FSM leaves IDLE to issue the head entry.
   assign pop       = (state_q == IDLE) && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= hostInstruction;
      end
   end

   // Next-state and registered-output logic. coreValid_q is set on the
   // IDLE->ISSUE transition, so the pulse coincides exactly with ISSUE.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      instr_d   = instr_q;
      valid_d   = 1'b0;
      flag_d    = flag_q;
      issued_d  = issued_q;
      dropped_d = dropped_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               instr_d = mem[rd_ptr_q];
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = BUSY;
         end
         BUSY: begin
            timer_d = timer_q + TW'(1);
            // Completion wins over the watchdog when both land in the same cycle.
            if (coreComplete) begin
               issued_d = issued_q + COUNT_WIDTH'(1);
               state_d  = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               dropped_d = dropped_q + COUNT_WIDTH'(1);
               flag_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= IDLE;
         timer_q   <= '0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         flag_q    <= 1'b0;
         issued_q  <= '0;
         dropped_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         flag_q    <= flag_d;
         issued_q  <= issued_d;
         dropped_q <= dropped_d;
      end
   end

   assign coreInstruction = instr_q;
   assign coreValid       = valid_q;
   assign queueCount      = count_q;
   assign busy            = (state_q != IDLE);
   assign timeoutFlag     = flag_q;
   assign issuedCount     = issued_q;
   assign droppedCount    = dropped_q;

`ifdef DISPATCH_PERF_EN
   logic [COUNT_WIDTH-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = idle_q;
      if ((state_q == IDLE) && (count_q == '0)) begin
         idle_d = idle_q + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign idleCycles = idle_q;
`else
   assign idleCycles = '0;
`endif

endmodule

// File: tb/tb_instruction_dispatcher.sv
// -----------------------------------------------------------------------------
// Testbench for instruction_dispatcher. It includes a core responder whose
// completion latency is chosen per issue. It also includes a transaction-level
// reference model. The model expects issues in push order, and it classifies
// each issue as completed when its latency is within 1..TIMEOUT, or as dropped
// otherwise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_dispatcher;

   localparam int unsigned DEPTH    = 8;
   localparam int unsigned TIMEOUT  = 16;
   localparam int unsigned CWID     = 32;
   localparam logic [31:0] ADD_INSN = 32'h002081B3;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [31:0]            hostInstruction = '0;
   logic                   hostValid = 1'b0;
   logic                   hostReady;
   logic [31:0]            coreInstruction;
   logic                   coreValid;
   logic                   coreComplete = 1'b0;
   logic [$clog2(DEPTH):0] queueCount;
   logic                   busy;
   logic                   timeoutFlag;
   logic [CWID-1:0]        issuedCount;
   logic [CWID-1:0]        droppedCount;
   logic [CWID-1:0]        idleCycles;

   instruction_dispatcher #(
      .DEPTH(DEPTH),
      .TIMEOUT(TIMEOUT),
      .COUNT_WIDTH(CWID)
   ) dut (
      .clk(clk),
      .reset(reset),
      .hostInstruction(hostInstruction),
      .hostValid(hostValid),
      .hostReady(hostReady),
      .coreInstruction(coreInstruction),
      .coreValid(coreValid),
      .coreComplete(coreComplete),
      .queueCount(queueCount),
      .busy(busy),
      .timeoutFlag(timeoutFlag),
      .issuedCount(issuedCount),
      .droppedCount(droppedCount),
      .idleCycles(idleCycles)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;

   // Reference model state
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int unsigned obs_cyc[$];
   int unsigned obs_lat[$];
   int unsigned exp_issued  = 0;
   int unsigned exp_dropped = 0;
   logic        exp_flag    = 1'b0;

   // Responder controls (0 latency = never complete)
   int unsigned core_lat    = 4;
   bit          lat_random  = 1'b0;
   bit          spurious_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Core model: it completes `lat` cycles after the issue pulse.
   // A new issue replaces any completion that is still pending.
   initial begin : core_model
      int unsigned pend;
      int unsigned lat;
      int unsigned r;
      pend = 0;
      forever begin
         @(posedge clk);
         #2;
         coreComplete = 1'b0;
         if (reset !== 1'b1) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) coreComplete = 1'b1;
            end
            if (coreValid === 1'b1) begin
               if (lat_random) begin
                  r = $urandom_range(9);
                  if (r == 0)      lat = 0;
                  else if (r <= 7) lat = $urandom_range(TIMEOUT, 1);
                  else             lat = $urandom_range(TIMEOUT + 6, TIMEOUT + 1);
               end else begin
                  lat = core_lat;
               end
               obs_lat.push_back(lat);
               pend = lat;
            end else if (spurious_en && pend == 0 && coreComplete == 1'b0 &&
                         busy === 1'b0 && $urandom_range(3) == 0) begin
               coreComplete = 1'b1;
            end
         end
      end
   end

   // Issue monitor: it logs each issue, checks that every pulse lasts one cycle,
   // and checks that the instruction stays stable while BUSY.
   initial begin : monitor
      logic        prev_valid;
      logic [31:0] held;
      prev_valid = 1'b0;
      held       = '0;
      forever begin
         @(posedge clk);
         #2;
         if (coreValid === 1'b1) begin
            check("valid_one_cycle", prev_valid, 1'b0);
            obs_q.push_back(coreInstruction);
            obs_cyc.push_back(cyc);
            held = coreInstruction;
         end else if (busy === 1'b1 && reset === 1'b1) begin
            check("instr_held", coreInstruction, held);
         end
         prev_valid = coreValid;
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic clear_model();
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
      obs_lat.delete();
      exp_issued  = 0;
      exp_dropped = 0;
      exp_flag    = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] ins);
      int unsigned k;
      k = 0;
      hostInstruction = ins;
      hostValid       = 1'b1;
      while (hostReady !== 1'b1 && k < 200) begin
         step(1);
         k++;
      end
      if (k >= 200) check("push_timeout", hostReady, 1'b1);
      if (hostReady === 1'b1) exp_q.push_back(ins);
      step(1);
      hostValid = 1'b0;
   endtask

   task automatic push_burst(input int unsigned n);
      logic [31:0] ins;
      for (int i = 0; i < int'(n); i++) begin
         ins             = $urandom();
         hostInstruction = ins;
         hostValid       = 1'b1;
         if (hostReady === 1'b1) exp_q.push_back(ins);
         step(1);
      end
      hostValid = 1'b0;
   endtask

   task automatic wait_issue(input string tag);
      int unsigned n0;
      int unsigned k;
      n0 = obs_q.size();
      k  = 0;
      while (obs_q.size() == n0 && k < 100) begin
         step(1);
         k++;
      end
      check({tag, "_issue_seen"}, obs_q.size() > n0, 1'b1);
   endtask

   task automatic drain(input string tag, input int unsigned limit);
      int unsigned k;
      logic        done;
      k    = 0;
      done = 1'b0;
      while (!done && k < limit) begin
         done = (obs_q.size() == exp_q.size()) && (busy === 1'b0) && (queueCount === '0);
         if (!done) begin
            step(1);
            k++;
         end
      end
      check({tag, "_drained"}, done, 1'b1);
   endtask

   task automatic compare_phase(input string tag);
      check({tag, "_n_issued"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check({tag, "_order"}, obs_q[i], exp_q[i]);
      foreach (obs_lat[i]) begin
         if (obs_lat[i] >= 1 && obs_lat[i] <= TIMEOUT) begin
            exp_issued++;
         end else begin
            exp_dropped++;
            exp_flag = 1'b1;
         end
      end
      check({tag, "_issuedCount"}, issuedCount, exp_issued);
      check({tag, "_droppedCount"}, droppedCount, exp_dropped);
      check({tag, "_timeoutFlag"}, timeoutFlag, exp_flag);
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
      obs_lat.delete();
   endtask

   initial begin : stim
      int unsigned t0;
      int unsigned gap;
      int unsigned k;
      logic [31:0] exp_idle;

      // ---------------- reset
      reset = 1'b0;
      step(2);
      check("rst_hostReady", hostReady, 1'b1);
      check("rst_coreValid", coreValid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_queueCount", queueCount, 0);
      check("rst_timeoutFlag", timeoutFlag, 1'b0);
      check("rst_issuedCount", issuedCount, 0);
      check("rst_droppedCount", droppedCount, 0);
      check("rst_idleCycles", idleCycles, 0);
      check("rst_coreInstruction", coreInstruction, 0);
      clear_model();
      reset = 1'b1;
      step(1);

      // ---------------- single ADD: latency and pulse shape
      core_lat        = 4;
      t0              = cyc;
      hostInstruction = ADD_INSN;
      hostValid       = 1'b1;
      if (hostReady === 1'b1) exp_q.push_back(ADD_INSN);
      step(1);
      hostValid = 1'b0;
      check("add_count_n1", queueCount, 1);
      check("add_valid_n1", coreValid, 1'b0);
      step(1);
      check("add_valid_n2", coreValid, 1'b1);
      check("add_instr_n2", coreInstruction, ADD_INSN);
      check("add_count_n2", queueCount, 0);
      step(1);
      check("add_valid_n3", coreValid, 1'b0);
      check("add_busy_n3", busy, 1'b1);
      step(3);
      check("add_busy_n6", busy, 1'b1);
      check("add_issued_n6", issuedCount, 0);
      step(1);
      check("add_busy_n7", busy, 1'b0);
      check("add_issue_cycle", (obs_cyc.size() > 0) ? obs_cyc[0] - t0 : 0, 2);
      compare_phase("add");

      // ---------------- fill to DEPTH behind a blocker completing on the last timer cycle
      core_lat = TIMEOUT;
      push_one($urandom());
      wait_issue("fill_blocker");
      core_lat = 4;
      push_burst(DEPTH);
      check("fill_count_full", queueCount, DEPTH);
      check("fill_hostReady_low", hostReady, 1'b0);
      hostInstruction = 32'hDEAD_BEEF;
      hostValid       = 1'b1;
      step(1);
      hostValid = 1'b0;
      check("fill_count_held", queueCount, DEPTH);
      drain("fill", 400);
      if (obs_cyc.size() == DEPTH + 1) begin
         check("fill_gap_last_timer", obs_cyc[1] - obs_cyc[0], TIMEOUT + 2);
         for (int i = 1; i < int'(DEPTH); i++)
            check("fill_period", obs_cyc[i + 1] - obs_cyc[i], 6);
      end else begin
         check("fill_issue_log", obs_cyc.size(), DEPTH + 1);
      end
      check("fill_hostReady_back", hostReady, 1'b1);
      compare_phase("fill");

      // ---------------- watchdog drop, then the next queued instruction issues
      core_lat = 0;
      push_one($urandom());
      wait_issue("drop_x");
      core_lat = 4;
      push_one($urandom());
      drain("drop", 200);
      if (obs_cyc.size() == 2)
         check("drop_gap", obs_cyc[1] - obs_cyc[0], TIMEOUT + 2);
      else
         check("drop_issue_log", obs_cyc.size(), 2);
      compare_phase("drop");
      push_one($urandom());
      drain("sticky", 100);
      compare_phase("sticky");

      // ---------------- push coinciding with pop at count 3
      core_lat = TIMEOUT;
      push_one($urandom());
      wait_issue("pp_blocker");
      core_lat = 4;
      push_burst(3);
      check("pp_count3", queueCount, 3);
      k = 0;
      while (busy !== 1'b0 && k < 100) begin
         step(1);
         k++;
      end
      check("pp_idle_reached", busy, 1'b0);
      hostInstruction = $urandom();
      hostValid       = 1'b1;
      if (hostReady === 1'b1) exp_q.push_back(hostInstruction);
      step(1);
      hostValid = 1'b0;
      check("pp_count_unchanged", queueCount, 3);
      check("pp_issue", coreValid, 1'b1);
      drain("pp", 200);
      compare_phase("pp");

      // ---------------- randomized traffic with spurious idle completions
      lat_random  = 1'b1;
      spurious_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         gap = $urandom_range(3);
         step(gap);
         push_one($urandom());
      end
      drain("rand", 3000);
      lat_random  = 1'b0;
      spurious_en = 1'b0;
      compare_phase("rand");

      // ---------------- reset while BUSY, then idle-cycle counting
      core_lat = 4;
      push_burst(3);
      wait_issue("rb");
      step(1);
      check("rb_busy_before", busy, 1'b1);
      reset = 1'b0;
      step(1);
      check("rb_busy", busy, 1'b0);
      check("rb_queueCount", queueCount, 0);
      check("rb_coreValid", coreValid, 1'b0);
      check("rb_hostReady", hostReady, 1'b1);
      check("rb_issuedCount", issuedCount, 0);
      check("rb_droppedCount", droppedCount, 0);
      check("rb_timeoutFlag", timeoutFlag, 1'b0);
      clear_model();
      reset = 1'b1;
      step(10);
`ifdef DISPATCH_PERF_EN
      exp_idle = 10;
`else
      exp_idle = 0;
`endif
      check("rb_idleCycles", idleCycles, exp_idle);
      check("rb_no_reissue", obs_q.size(), 0);
      check("rb_still_idle", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
